// File: rtl/jt51_wrseq_pkg.sv
// Shared definitions for the jt51 register-write sequencer: FSM states,
// the busy bit position and phase-length helpers.
package jt51_wrseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_GAP    = 3'd2,
        ST_DATA   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_POLL   = 3'd5
    } state_t;

    localparam int BUSY_BIT   = 7;
    localparam int SETTLE_CYC = 2;

    // Phase counters run 0..N-1, so the exit test compares against N-1.
    function automatic logic [3:0] phase_last(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/jt51_wrseq_rr.sv
// Two-way round-robin arbiter. On a tie the requester not granted last wins;
// after reset requester 0 is favoured.
module jt51_wrseq_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant[0] = req[0] & (~req[1] | last);
        grant[1] = req[1] & (~req[0] | ~last);
    end

    // last=1 means requester 1 won most recently, which hands the next tie to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (accept)
            last <= grant[1];
    end

endmodule

// File: rtl/jt51_wrseq.sv
// Register-write sequencer for jt51: arbitrates two requesters and serialises
// each write into an address/gap/data bus cycle, then polls busy.
module jt51_wrseq
    import jt51_wrseq_pkg::*;
#(
    parameter int WR_CYC  = 2,
    parameter int GAP_CYC = 1,
    parameter int TIMEOUT = 255
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       req0_valid,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       chip_cs_n,
    output logic       chip_wr_n,
    output logic       chip_a0,
    output logic [7:0] chip_din,
    input  logic [7:0] chip_dout,
    output logic       active,
    output logic       timeout_err,
    input  logic       clr_err
);

    localparam logic [3:0] WR_LAST     = phase_last(WR_CYC);
    localparam logic [3:0] GAP_LAST    = phase_last(GAP_CYC);
    localparam logic [3:0] SETTLE_LAST = phase_last(SETTLE_CYC);
    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] phase;
    logic [7:0] tmo;
    logic [7:0] data_q;
    logic [1:0] grant;
    logic       idle;
    logic       accept;
    logic       busy;
    logic       unused_dout;

    assign idle        = (state == ST_IDLE);
    assign req0_ready  = idle & grant[0] & ~rst;
    assign req1_ready  = idle & grant[1] & ~rst;
    assign accept      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign busy        = chip_dout[BUSY_BIT];
    assign unused_dout = ^chip_dout[6:0];

    jt51_wrseq_rr u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    // Acceptance in IDLE ignores cen so a write can start on any clk; every
    // other state only advances on cen ticks. A timeout set overrides clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase       <= 4'd0;
            tmo         <= 8'd0;
            data_q      <= 8'd0;
            chip_cs_n   <= 1'b1;
            chip_wr_n   <= 1'b1;
            chip_a0     <= 1'b0;
            chip_din    <= 8'd0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (clr_err)
                timeout_err <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    state     <= ST_ADDR;
                    phase     <= 4'd0;
                    chip_cs_n <= 1'b0;
                    chip_wr_n <= 1'b0;
                    chip_a0   <= 1'b0;
                    chip_din  <= grant[1] ? req1_addr : req0_addr;
                    data_q    <= grant[1] ? req1_data : req0_data;
                    active    <= 1'b1;
                end
                ST_ADDR: if (cen) begin
                    if (phase == WR_LAST) begin
                        state     <= ST_GAP;
                        phase     <= 4'd0;
                        chip_cs_n <= 1'b1;
                        chip_wr_n <= 1'b1;
                    end else
                        phase <= phase + 4'd1;
                end
                ST_GAP: if (cen) begin
                    if (phase == GAP_LAST) begin
                        state     <= ST_DATA;
                        phase     <= 4'd0;
                        chip_cs_n <= 1'b0;
                        chip_wr_n <= 1'b0;
                        chip_a0   <= 1'b1;
                        chip_din  <= data_q;
                    end else
                        phase <= phase + 4'd1;
                end
                ST_DATA: if (cen) begin
                    if (phase == WR_LAST) begin
                        state     <= ST_SETTLE;
                        phase     <= 4'd0;
                        chip_cs_n <= 1'b1;
                        chip_wr_n <= 1'b1;
                    end else
                        phase <= phase + 4'd1;
                end
                ST_SETTLE: if (cen) begin
                    if (phase == SETTLE_LAST) begin
                        state <= ST_POLL;
                        tmo   <= 8'd0;
                    end else
                        phase <= phase + 4'd1;
                end
                ST_POLL: if (cen) begin
                    if (!busy) begin
                        state  <= ST_IDLE;
                        active <= 1'b0;
                    end else if (tmo == TMO_LAST) begin
                        state       <= ST_IDLE;
                        active      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else
                        tmo <= tmo + 8'd1;
                end
                default: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt51_wrseq.sv
// Self-checking bench for jt51_wrseq: directed steps with a write scoreboard
// and a bus monitor that measures phase lengths in cen ticks.
module tb_jt51_wrseq;

    localparam int WR_CYC  = 2;
    localparam int GAP_CYC = 1;
    localparam int TIMEOUT = 255;
    localparam int MIN_LEN = WR_CYC + GAP_CYC + WR_CYC + 2 + 1;
    localparam int TMO_LEN = WR_CYC + GAP_CYC + WR_CYC + 2 + TIMEOUT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_addr = 8'd0, req0_data = 8'd0;
    logic [7:0] req1_addr = 8'd0, req1_data = 8'd0;
    logic       req0_ready, req1_ready;
    logic       chip_cs_n, chip_wr_n, chip_a0;
    logic [7:0] chip_din, chip_dout;
    logic       active, timeout_err;
    logic       clr_err = 1'b0;
    logic       busy = 1'b0;
    logic       cen_hold = 1'b0;

    int checks = 0;
    int passes = 0;

    logic [15:0] sb[$];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic        model_last = 1'b1;

    logic       mon_prev_cs_n = 1'b1;
    logic       mon_prev_active = 1'b0;
    logic       mon_tick;
    int         mon_phase_idx = 0;
    int         mon_low_ticks = 0;
    int         mon_gap_ticks = 0;
    logic       mon_in_gap = 1'b0;
    int         mon_wticks = 0;
    logic [7:0] mon_addr = 8'd0;
    logic [15:0] mon_exp;
    int         fall_count = 0;
    int         last_wticks = 0;

    assign chip_dout = {busy, 7'd0};

    jt51_wrseq #(.WR_CYC(WR_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .rst         (rst),
        .clk         (clk),
        .cen         (cen),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .chip_cs_n   (chip_cs_n),
        .chip_wr_n   (chip_wr_n),
        .chip_a0     (chip_a0),
        .chip_din    (chip_din),
        .chip_dout   (chip_dout),
        .active      (active),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    initial forever #5 clk = ~clk;

    // cen runs at half the clk rate unless stalled.
    initial forever begin
        @(negedge clk);
        if (cen_hold) cen = 1'b0;
        else          cen = ~cen;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    endtask

    // Bus monitor: samples 1 time unit after each rising edge; mon_tick is
    // the cen value that qualified that edge.
    always begin
        @(posedge clk);
        mon_tick = cen;
        #1;
        if (rst) begin
            mon_prev_cs_n   = 1'b1;
            mon_prev_active = 1'b0;
            mon_phase_idx   = 0;
            mon_low_ticks   = 0;
            mon_gap_ticks   = 0;
            mon_in_gap      = 1'b0;
            mon_wticks      = 0;
        end else begin
            if (!mon_prev_cs_n && mon_tick) mon_low_ticks++;
            if (mon_in_gap && mon_prev_cs_n && mon_tick) mon_gap_ticks++;
            if (mon_prev_active && mon_tick) mon_wticks++;
            if (mon_prev_cs_n && !chip_cs_n) begin
                fall_count++;
                if (mon_phase_idx == 0) begin
                    checkOutput("addr_phase_a0", chip_a0, 1'b0);
                    mon_addr      = chip_din;
                    mon_phase_idx = 1;
                end else begin
                    checkOutput("data_phase_a0", chip_a0, 1'b1);
                    checkOutput("gap_ticks", mon_gap_ticks, GAP_CYC);
                    mon_in_gap    = 1'b0;
                    mon_phase_idx = 0;
                    checkOutput("sb_pending", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        mon_exp = sb.pop_front();
                        checkOutput("write_addr_data", {mon_addr, chip_din}, mon_exp);
                    end
                end
            end
            if (!mon_prev_cs_n && chip_cs_n) begin
                checkOutput("wr_phase_ticks", mon_low_ticks, WR_CYC);
                mon_low_ticks = 0;
                if (mon_phase_idx == 1) begin
                    mon_in_gap    = 1'b1;
                    mon_gap_ticks = 0;
                end
            end
            if (mon_prev_active && !active) begin
                last_wticks = mon_wticks;
                mon_wticks  = 0;
            end
            mon_prev_cs_n   = chip_cs_n;
            mon_prev_active = active;
        end
    end

    // Presents queued writes, predicts the round-robin grant and pushes the
    // predicted write onto the scoreboard when it is accepted.
    task automatic applyStimulus(input int budget);
        int   cyc = 0;
        logic g0, g1;
        while ((q0.size() != 0 || q1.size() != 0) && cyc < budget) begin
            @(negedge clk);
            req0_valid = (q0.size() != 0);
            req1_valid = (q1.size() != 0);
            if (req0_valid) {req0_addr, req0_data} = q0[0];
            if (req1_valid) {req1_addr, req1_data} = q1[0];
            #1;
            if (req0_ready || req1_ready) begin
                g0 = req0_valid & (~req1_valid | model_last);
                g1 = req1_valid & (~req0_valid | ~model_last);
                checkOutput("grant", {req1_ready, req0_ready}, {g1, g0});
                if (g1) begin
                    sb.push_back(q1.pop_front());
                    model_last = 1'b1;
                end else if (g0) begin
                    sb.push_back(q0.pop_front());
                    model_last = 1'b0;
                end
            end
            cyc++;
        end
        checkOutput("accept_in_time", (q0.size() == 0 && q1.size() == 0), 1'b1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int cyc = 0;
        do begin
            @(posedge clk);
            #2;
            cyc++;
        end while ((active || sb.size() != 0) && cyc < budget);
        checkOutput("idle_in_time", (!active && sb.size() == 0), 1'b1);
    endtask

    task automatic waitActiveFall(input int budget);
        int cyc = 0;
        do begin
            @(posedge clk);
            #2;
            cyc++;
        end while (active && cyc < budget);
        checkOutput("active_fall_in_time", active, 1'b0);
    endtask

    task automatic waitTicks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (cen) k++;
        end
        #2;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        model_last = 1'b1;
    endtask

    initial begin
        int         f0;
        int         cyc;
        logic [11:0] snap;

        // Reset values, including ready gated low while rst is high.
        repeat (3) @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checkOutput("rst_ready0", req0_ready, 1'b0);
        checkOutput("rst_ready1", req1_ready, 1'b0);
        checkOutput("rst_cs_n", chip_cs_n, 1'b1);
        checkOutput("rst_wr_n", chip_wr_n, 1'b1);
        checkOutput("rst_a0", chip_a0, 1'b0);
        checkOutput("rst_din", chip_din, 8'h00);
        checkOutput("rst_active", active, 1'b0);
        checkOutput("rst_timeout_err", timeout_err, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Single write with busy low: minimum length.
        q0.push_back(16'h20C7);
        applyStimulus(20);
        waitIdle(200);
        checkOutput("single_len_ticks", last_wticks, MIN_LEN);

        // Contention: both requesters valid, grants must alternate from 0.
        doReset();
        q0.push_back(16'h1101); q0.push_back(16'h1202); q0.push_back(16'h1303);
        q1.push_back(16'h2111); q1.push_back(16'h2212); q1.push_back(16'h2313);
        applyStimulus(400);
        waitIdle(200);

        // Busy held high for 40+ POLL ticks: no new write, no timeout.
        busy = 1'b1;
        q0.push_back(16'h30A5);
        applyStimulus(20);
        waitTicks(WR_CYC + GAP_CYC + WR_CYC + 2 + 40);
        f0 = fall_count;
        req1_valid = 1'b1;
        req1_addr  = 8'h31;
        req1_data  = 8'h5A;
        #1;
        checkOutput("busy_ready1_low", req1_ready, 1'b0);
        checkOutput("busy_active", active, 1'b1);
        checkOutput("busy_cs_n", chip_cs_n, 1'b1);
        checkOutput("busy_no_err", timeout_err, 1'b0);
        waitTicks(5);
        checkOutput("busy_no_new_cs", fall_count, f0);
        req1_valid = 1'b0;
        busy = 1'b0;
        waitIdle(50);
        checkOutput("busy_no_err_after", timeout_err, 1'b0);
        q1.push_back(16'h315A);
        applyStimulus(20);
        waitIdle(200);

        // Timeout with busy stuck high.
        busy = 1'b1;
        q0.push_back(16'h40E1);
        applyStimulus(20);
        waitActiveFall(1000);
        checkOutput("tmo_err_set", timeout_err, 1'b1);
        checkOutput("tmo_len_ticks", last_wticks, TMO_LEN);
        busy = 1'b0;
        q1.push_back(16'h4133);
        applyStimulus(20);
        waitIdle(200);
        checkOutput("tmo_err_sticky", timeout_err, 1'b1);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checkOutput("tmo_err_cleared", timeout_err, 1'b0);

        // Set wins over a coincident clr_err.
        busy    = 1'b1;
        clr_err = 1'b1;
        q0.push_back(16'h4244);
        applyStimulus(20);
        waitActiveFall(1000);
        checkOutput("tmo_set_wins", timeout_err, 1'b1);
        @(posedge clk);
        #2;
        checkOutput("tmo_clr_next", timeout_err, 1'b0);
        clr_err = 1'b0;
        busy    = 1'b0;

        // Reset during the data phase: async return to reset values, no retry.
        q0.push_back(16'h50F0);
        applyStimulus(20);
        cyc = 0;
        do begin
            @(posedge clk);
            #2;
            cyc++;
        end while (!(chip_cs_n == 1'b0 && chip_a0 == 1'b1) && cyc < 50);
        checkOutput("rst_mid_in_data", {chip_cs_n, chip_a0}, 2'b01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_cs_n", chip_cs_n, 1'b1);
        checkOutput("rst_mid_wr_n", chip_wr_n, 1'b1);
        checkOutput("rst_mid_a0", chip_a0, 1'b0);
        checkOutput("rst_mid_din", chip_din, 8'h00);
        checkOutput("rst_mid_active", active, 1'b0);
        @(negedge clk);
        rst        = 1'b0;
        model_last = 1'b1;
        f0 = fall_count;
        repeat (30) @(posedge clk);
        #2;
        checkOutput("rst_mid_no_retry", fall_count, f0);
        checkOutput("rst_mid_idle", active, 1'b0);
        checkOutput("rst_mid_sb_empty", sb.size(), 0);

        // cen stall during the address phase.
        q0.push_back(16'h60B6);
        applyStimulus(20);
        #1;
        cen_hold = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        snap = {chip_cs_n, chip_wr_n, chip_a0, active, chip_din};
        repeat (10) @(posedge clk);
        #2;
        checkOutput("stall_frozen", {chip_cs_n, chip_wr_n, chip_a0, active, chip_din}, snap);
        checkOutput("stall_in_addr", {chip_cs_n, chip_a0, chip_din}, {2'b00, 8'h60});
        cen_hold = 1'b0;
        waitIdle(200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
